// File: rtl/llr_loader_pkg.sv
// Shared definitions for the channel-LLR loader and its helpers.
//   LLR_DATA_WIDTH / LLR_ADDR_WIDTH : default stored LLR width and RAM pair-address width
//   LLR_SAT_MAX                     : symmetric saturation magnitude at the default width
//   llr_state_t                     : loader FSM states
//   llr_sat_max()                   : symmetric saturation magnitude for any width
package llr_loader_pkg;

    localparam int LLR_DATA_WIDTH = 5;
    localparam int LLR_ADDR_WIDTH = 8;
    localparam int LLR_SAT_MAX    = (1 << (LLR_DATA_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } llr_state_t;

    // Largest magnitude kept after saturation; the most negative code is never used
    // so the stored range stays symmetric around zero.
    function automatic int llr_sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/llr_saturate.sv
// Combinational symmetric clamp of a two's-complement LLR from IN_WIDTH to DATA_WIDTH bits.
//   raw_llr : IN_WIDTH-bit signed channel LLR
//   sat_llr : DATA_WIDTH-bit signed LLR limited to +/-(2^(DATA_WIDTH-1)-1)
module llr_saturate
    import llr_loader_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = LLR_DATA_WIDTH
) (
    input  logic [IN_WIDTH-1:0]   raw_llr,
    output logic [DATA_WIDTH-1:0] sat_llr
);

    localparam int MAX_VAL = llr_sat_max(DATA_WIDTH);
    localparam logic signed [IN_WIDTH-1:0] POS_LIM = IN_WIDTH'(MAX_VAL);
    localparam logic signed [IN_WIDTH-1:0] NEG_LIM = IN_WIDTH'(-MAX_VAL);

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [IN_WIDTH-1:0] x);
        if (x > POS_LIM) begin
            return DATA_WIDTH'(MAX_VAL);
        end else if (x < NEG_LIM) begin
            return DATA_WIDTH'(-MAX_VAL);
        end else begin
            return x[DATA_WIDTH-1:0];
        end
    endfunction

    assign sat_llr = saturate(raw_llr);

endmodule

// File: rtl/llr_loader.sv
// Loads a frame of channel LLRs into the dual-bank intrinsic RAM, two samples per address,
// then hands the RAM to the decoder until it releases it.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/in_ready/in_llr/in_last : sample stream (transfer on in_valid && in_ready)
//   frame_ready      : a complete frame is resident and the decoder owns the RAM
//   frame_release    : decoder pulse returning the RAM to the loader
//   frame_err        : framing error for the resident frame (early or missing in_last)
//   ram_own          : loader is driving the RAM port
//   ram_address, ram_data_in[0:1], ram_we, ram_cs : pair write port ([0] even, [1] odd)
module llr_loader
    import llr_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LLR_DATA_WIDTH,
    parameter int ADDR_WIDTH = LLR_ADDR_WIDTH,
    parameter int IN_WIDTH   = 8,
    parameter int FRAME_LEN  = 2 * (1 << ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_llr,
    input  logic                  in_last,
    output logic                  frame_ready,
    input  logic                  frame_release,
    output logic                  frame_err,
    output logic                  ram_own,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in [0:1],
    output logic [1:0]            ram_we,
    output logic [1:0]            ram_cs
);

    // One extra bit so the sample index spans a full 2*(1<<ADDR_WIDTH) frame.
    localparam int KW = ADDR_WIDTH + 1;
    localparam logic [KW-1:0] LAST_K = KW'(FRAME_LEN - 1);

    llr_state_t            state;
    logic [KW-1:0]         k;
    logic [DATA_WIDTH-1:0] pair_even;
    logic                  err_pend;
    logic [DATA_WIDTH-1:0] sat_llr;
    logic                  accept;
    logic                  is_last;
    logic                  frame_end;

    llr_saturate #(
        .IN_WIDTH  (IN_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_saturate (
        .raw_llr(in_llr),
        .sat_llr(sat_llr)
    );

    assign accept    = (state == LOAD) && in_valid && in_ready;
    assign is_last   = (k == LAST_K);
    // The frame closes on in_last or when the RAM is full, whichever comes first.
    assign frame_end = accept && (in_last || is_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD;
            k              <= '0;
            pair_even      <= '0;
            err_pend       <= 1'b0;
            in_ready       <= 1'b0;
            ram_own        <= 1'b1;
            ram_we         <= 2'b00;
            ram_cs         <= 2'b00;
            ram_address    <= '0;
            ram_data_in[0] <= '0;
            ram_data_in[1] <= '0;
            frame_ready    <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            // Write strobe and RAM bus are single-cycle; they idle at zero otherwise.
            ram_we         <= 2'b00;
            ram_cs         <= 2'b00;
            ram_address    <= '0;
            ram_data_in[0] <= '0;
            ram_data_in[1] <= '0;

            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    ram_own  <= 1'b1;
                    if (accept) begin
                        if (k[0] || frame_end) begin
                            // Odd sample completes the pair; an early end on an even
                            // sample writes a half pair with the odd slot zeroed.
                            ram_we         <= 2'b11;
                            ram_cs         <= 2'b11;
                            ram_address    <= k[ADDR_WIDTH:1];
                            ram_data_in[0] <= k[0] ? pair_even : sat_llr;
                            ram_data_in[1] <= k[0] ? sat_llr : '0;
                        end else begin
                            pair_even <= sat_llr;
                        end

                        if (frame_end) begin
                            state     <= FLUSH;
                            in_ready  <= 1'b0;
                            // Error when in_last and the full-frame index disagree.
                            err_pend  <= in_last ^ is_last;
                            k         <= '0;
                            pair_even <= '0;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end

                FLUSH: begin
                    state       <= DONE;
                    in_ready    <= 1'b0;
                    ram_own     <= 1'b0;
                    frame_ready <= 1'b1;
                    frame_err   <= err_pend;
                end

                DONE: begin
                    if (frame_release) begin
                        state       <= LOAD;
                        k           <= '0;
                        err_pend    <= 1'b0;
                        in_ready    <= 1'b1;
                        ram_own     <= 1'b1;
                        frame_ready <= 1'b0;
                        frame_err   <= 1'b0;
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llr_loader.sv
module tb_llr_loader;

    localparam int DW    = 5;
    localparam int AW    = 8;
    localparam int IW    = 8;
    localparam int FRAME = 512;
    localparam int NTBL  = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_llr;
    logic          in_last;
    logic          frame_ready;
    logic          frame_release;
    logic          frame_err;
    logic          ram_own;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in [0:1];
    logic [1:0]    ram_we;
    logic [1:0]    ram_cs;

    llr_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .IN_WIDTH  (IW),
        .FRAME_LEN (FRAME)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_llr       (in_llr),
        .in_last      (in_last),
        .frame_ready  (frame_ready),
        .frame_release(frame_release),
        .frame_err    (frame_err),
        .ram_own      (ram_own),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_we       (ram_we),
        .ram_cs       (ram_cs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int a;
        int b;
        int e0;
        int e1;
    } tv_t;
    tv_t tbl [NTBL];

    typedef struct {
        int addr;
        int d0;
        int d1;
        int we;
        int cs;
    } wr_t;
    wr_t caps[$];

    int samp [FRAME];

    // Observed RAM writes, captured mid-cycle while the strobe is up.
    always @(negedge clk) begin
        if (rst_n && (ram_we != 2'b00 || ram_cs != 2'b00)) begin
            caps.push_back('{int'(ram_address), int'($signed(ram_data_in[0])),
                             int'($signed(ram_data_in[1])), int'(ram_we), int'(ram_cs)});
        end
    end

    // Reference clamp: symmetric limit of +/-15 for 5-bit storage.
    function automatic int sat_ref(input int v);
        int m;
        m = (1 << (DW - 1)) - 1;
        if (v > m) return m;
        if (v < -m) return -m;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) samp[i] = int'($urandom_range(255)) - 128;
    endtask

    // Drive n samples with random stalls, then check the frame hand-over timing and
    // every pair the loader wrote against the sample list.
    task automatic run_frame(input int n, input bit last_flag, input int stall_pct, input bit do_tbl);
        int  idx;
        int  cycles;
        int  np;
        int  exp_err;
        int  e0;
        int  e1;
        bit  v;
        bit  acc;
        caps.delete();
        idx    = 0;
        cycles = 0;
        while (idx < n && cycles < 20 * n + 100) begin
            v        = ($urandom_range(99) >= stall_pct);
            in_valid = v;
            in_llr   = v ? IW'(samp[idx]) : IW'($urandom);
            in_last  = v ? (last_flag && idx == n - 1) : 1'($urandom);
            frame_release = (cycles == 3);
            acc = v && in_ready;
            @(posedge clk);
            #1;
            frame_release = 1'b0;
            cycles++;
            if (acc) begin
                if (do_tbl && idx < 2 * NTBL && (idx % 2) == 1) begin
                    chk("tbl_we", int'(ram_we), 3);
                    chk("tbl_addr", int'(ram_address), idx / 2);
                    chk("tbl_even", int'($signed(ram_data_in[0])), tbl[idx / 2].e0);
                    chk("tbl_odd", int'($signed(ram_data_in[1])), tbl[idx / 2].e1);
                end
                idx++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (idx < n) begin
            chk("accept_timeout", idx, n);
            return;
        end
        exp_err = (n == FRAME && last_flag) ? 0 : 1;
        // Cycle after the final accept: last write strobe, input closed.
        chk("flush_in_ready", int'(in_ready), 0);
        chk("flush_we", int'(ram_we), 3);
        chk("flush_addr", int'(ram_address), (n - 1) / 2);
        chk("flush_own", int'(ram_own), 1);
        chk("flush_ready", int'(frame_ready), 0);
        frame_release = 1'b1;  // must be ignored outside DONE
        @(posedge clk);
        #1;
        frame_release = 1'b0;
        chk("done_ready", int'(frame_ready), 1);
        chk("done_err", int'(frame_err), exp_err);
        chk("done_own", int'(ram_own), 0);
        chk("done_in_ready", int'(in_ready), 0);
        chk("done_we", int'(ram_we), 0);
        @(posedge clk);
        #1;
        chk("done_ready_hold", int'(frame_ready), 1);
        np = (n + 1) / 2;
        chk("write_count", caps.size(), np);
        for (int i = 0; i < np && i < caps.size(); i++) begin
            e0 = sat_ref(samp[2 * i]);
            e1 = (2 * i + 1 < n) ? sat_ref(samp[2 * i + 1]) : 0;
            n_cmp++;
            if (caps[i].addr != i || caps[i].d0 != e0 || caps[i].d1 != e1 ||
                caps[i].we != 3 || caps[i].cs != 3) begin
                n_bad++;
                $display("FAIL write[%0d]: got addr=%0d data={%0d,%0d} we=%0d cs=%0d expected addr=%0d data={%0d,%0d} we=3 cs=3",
                         i, caps[i].addr, caps[i].d0, caps[i].d1, caps[i].we, caps[i].cs, i, e0, e1);
            end
        end
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        @(posedge clk);
        #1;
        frame_release = 1'b0;
        chk("rel_in_ready", int'(in_ready), 1);
        chk("rel_ready", int'(frame_ready), 0);
        chk("rel_err", int'(frame_err), 0);
        chk("rel_own", int'(ram_own), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_own"}, int'(ram_own), 1);
        chk({tag, "_we"}, int'(ram_we), 0);
        chk({tag, "_cs"}, int'(ram_cs), 0);
        chk({tag, "_addr"}, int'(ram_address), 0);
        chk({tag, "_d0"}, int'(ram_data_in[0]), 0);
        chk({tag, "_d1"}, int'(ram_data_in[1]), 0);
        chk({tag, "_ready"}, int'(frame_ready), 0);
        chk({tag, "_err"}, int'(frame_err), 0);
    endtask

    initial begin
        tbl[0] = '{100, -128, 15, -15};
        tbl[1] = '{15, -15, 15, -15};
        tbl[2] = '{16, -16, 15, -15};
        tbl[3] = '{127, -127, 15, -15};
        tbl[4] = '{0, -1, 0, -1};
        tbl[5] = '{-14, 14, -14, 14};
        tbl[6] = '{-16, 17, -15, 15};
        tbl[7] = '{5, -5, 5, -5};

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_llr        = '0;
        in_last       = 1'b0;
        frame_release = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", int'(in_ready), 1);

        // Full frame: saturation table first, then random samples, in_last on 511.
        fill_random(FRAME);
        for (int i = 0; i < NTBL; i++) begin
            samp[2 * i]     = tbl[i].a;
            samp[2 * i + 1] = tbl[i].b;
        end
        run_frame(FRAME, 1'b1, 0, 1'b1);
        release_frame();

        // Early in_last on even sample 4: half pair at address 2.
        fill_random(5);
        run_frame(5, 1'b1, 30, 1'b0);
        release_frame();

        // Early in_last on odd sample 7.
        fill_random(8);
        run_frame(8, 1'b1, 30, 1'b0);
        release_frame();

        // Reset after sample 3 is accepted discards the partial frame.
        fill_random(4);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_llr   = IW'(samp[i]);
            in_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_we", int'(ram_we), 3);
        chk("pre_reset_addr", int'(ram_address), 1);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_reset_we", int'(ram_we), 0);
        chk("after_reset_in_ready", int'(in_ready), 1);

        // Full frame with random stalls and no in_last: completes with an error flag.
        fill_random(FRAME);
        run_frame(FRAME, 1'b0, 40, 1'b0);
        release_frame();

        // Random short frames with random stalls.
        for (int f = 0; f < 4; f++) begin
            int n;
            n = int'($urandom_range(80, 1));
            fill_random(n);
            run_frame(n, 1'b1, 35, 1'b0);
            release_frame();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
